pixel_packer_axis: RTL
======================

Name: pixel_packer_axis

Overview:
- Downstream neighbour of the histogram equalization core: consumes its 8-bit equalized pixel AXI4-Stream.
- Packs consecutive pixels into OUT_BYTES-wide words for the DMA S2MM channel, with TKEEP on the final partial word of a frame.
- Registered output stage; per-frame pixel count and a frame-done pulse for the control/status logic.

Parameters:
- OUT_BYTES, 4, pixels (bytes) per output word; legal range 2..8; output width is 8*OUT_BYTES.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8  equalized pixel from core.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when tvalid&tready.
- s_axis_tlast  in  1  last pixel of frame.
- m_axis_tdata  out  8*OUT_BYTES  packed word to DMA; pixel k of word in bits [8k+7:8k].
- m_axis_tkeep  out  OUT_BYTES  byte-lane valid mask.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  DMA ready.
- m_axis_tlast  out  1  word carries frame's last pixel.
- pixel_count  out  32  pixels accepted in current frame, including a TLAST pixel (holds until next frame's first pixel).
- frame_done  out  1  one-cycle pulse on M handshake of the tlast word.

Behaviour:
- Reset (synchronous, active-high; takes priority over all else): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, frame_done=0, pixel_count=0, lane index=0, accumulator=0. A partially packed word is discarded; no output word is produced for it.
- s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational on registered m_axis_tvalid and input m_axis_tready only; never on s_axis_tvalid). During reset, s_axis_tready=0.
- Accept (s_axis_tvalid & s_axis_tready):
  - Byte goes into accumulator lane idx.
  - If idx==OUT_BYTES-1 or s_axis_tlast=1 ("completing beat"), the output register loads on the same edge:
    - tdata = accumulator with the new byte; lanes above idx are 0.
    - tkeep = (idx+1) low ones.
    - tlast = s_axis_tlast.
    - m_axis_tvalid=1.
    - idx and accumulator clear to 0.
  - Otherwise idx increments.
- Latency: completing beat accepted on edge N produces m_axis_tvalid=1 after edge N. One pixel per cycle sustained while m_axis_tready=1; peak output rate is one word per OUT_BYTES cycles.
- Output hold: while m_axis_tvalid=1 and m_axis_tready=0, tdata/tkeep/tlast are held stable and s_axis_tready=0. No input beat is accepted, including non-completing ones.
- Simultaneous M handshake and a new completing S beat on the same edge: the output register reloads with the new word and m_axis_tvalid stays 1. M handshake with no completing beat: m_axis_tvalid goes to 0.
- pixel_count:
  - Increments by 1 on every accepted pixel, saturating at 2^32-1.
  - Reloads to 1 on the first pixel after a TLAST pixel was accepted (tracked by an internal flag set by a TLAST accept).
- frame_done: 1 for exactly the cycle after the edge on which m_axis_tvalid & m_axis_tready & m_axis_tlast.
- tlast with idx==OUT_BYTES-1 yields a full word with tkeep all ones and tlast=1.
- Back-to-back frames: the next frame's first pixel lands in lane 0 of a fresh word. Words never straddle frames.
- Stable-hold rule: m_axis_tvalid never drops without a handshake except on reset.

Test Plan:
- OUT_BYTES=4; send 8 pixels 0x01..0x08 with tlast on 0x08; m_axis_tready=1 -> two words: 0x04030201 (tkeep 0xF, tlast 0) and 0x08070605 (tkeep 0xF, tlast 1). frame_done pulses once; pixel_count=8.
- Send 6 pixels 0xA0..0xA5 with tlast on 0xA5 -> words 0xA3A2A1A0 (keep 0xF), then 0x0000A5A4 (keep 0x3, tlast 1).
- Single-pixel frame 0x7F with tlast -> word 0x0000007F, tkeep 0x1, tlast 1, pixel_count=1.
- Hold m_axis_tready=0 for 10 cycles after the first word is valid -> s_axis_tready=0 throughout, output stable. Releasing it resumes with no loss or duplication across a 16-pixel frame.
- Continuous input with m_axis_tready=1 -> s_axis_tready never drops, and 4 words emerge at 1-per-4-cycles. Also check a same-edge handshake plus completing-beat reload.
- Assert reset after 3 pixels of a frame -> all outputs return to reset values, and no word is emitted. A subsequent 4-pixel frame 0x11..0x14 yields 0x14131211 with tlast 1.

Source files
------------

// File: rtl/pixel_packer_axis_if.sv
// Stream bundle for the pixel packer: 8-bit pixel input stream plus packed word output stream.
// The slave modport is the packer's view; the master modport is the surrounding system's view.
interface pixel_packer_axis_if #(
  parameter int OUT_BYTES = 4
);
  logic [7:0]             s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic                   s_axis_tlast;
  logic [8*OUT_BYTES-1:0] m_axis_tdata;
  logic [OUT_BYTES-1:0]   m_axis_tkeep;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/pixel_packer_axis.sv
// Packs consecutive 8-bit equalized pixels into OUT_BYTES-wide words for the DMA write channel,
// with a registered output stage, TKEEP on a frame's final partial word, and frame status.
module pixel_packer_axis #(
  parameter int OUT_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  pixel_packer_axis_if.slave      bus,
  output logic [31:0]             pixel_count,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(OUT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES - 1);

  logic [IDX_W-1:0]       idx;
  logic [8*OUT_BYTES-1:0] acc;
  logic                   new_frame;
  logic [8*OUT_BYTES-1:0] word_next;
  logic [OUT_BYTES-1:0]   keep_next;
  logic                   accept;
  logic                   complete;

  // The output slot is free when empty or being drained this cycle; never depends on s_axis_tvalid.
  assign bus.s_axis_tready = !reset && (!bus.m_axis_tvalid || bus.m_axis_tready);
  assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;
  assign complete          = accept && ((idx == LAST_IDX) || bus.s_axis_tlast);

  // Lanes above idx are already zero in acc because it clears whenever a word is emitted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    word_next = acc;
    keep_next = '0;
    for (int k = 0; k < OUT_BYTES; k++) begin
      if (IDX_W'(k) == idx) word_next[8*k +: 8] = bus.s_axis_tdata;
      if (IDX_W'(k) <= idx) keep_next[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tkeep  <= '0;
      bus.m_axis_tlast  <= 1'b0;
      frame_done        <= 1'b0;
      pixel_count       <= '0;
      new_frame         <= 1'b0;
      idx               <= '0;
      acc               <= '0;
    end else begin
      frame_done <= bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast;

      if (bus.m_axis_tvalid && bus.m_axis_tready) bus.m_axis_tvalid <= 1'b0;

      // A completing beat overrides the drain above, so a same-edge reload keeps tvalid high.
      if (complete) begin
        bus.m_axis_tdata  <= word_next;
        bus.m_axis_tkeep  <= keep_next;
        bus.m_axis_tlast  <= bus.s_axis_tlast;
        bus.m_axis_tvalid <= 1'b1;
        idx               <= '0;
        acc               <= '0;
      end else if (accept) begin
        acc <= word_next;
        idx <= idx + 1'b1;
      end

      if (accept) begin
        if (new_frame)             pixel_count <= 32'd1;
        else if (pixel_count != '1) pixel_count <= pixel_count + 32'd1;
        new_frame <= bus.s_axis_tlast;
      end
    end
  end

endmodule
